// File: rtl/tow_pkg.sv
// Shared definitions for the Tug of War computer opponent.
//   cpu_state_t     : press-shaping FSM states
//   LFSR_W          : width of the LFSR and of the difficulty threshold
//   TAP_HI / TAP_LO : feedback taps of the 10-bit XNOR LFSR
//   max2()          : constant helper for counter sizing
package tow_pkg;

    localparam int LFSR_W = 10;
    localparam int TAP_HI = 9;
    localparam int TAP_LO = 6;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        RELEASE
    } cpu_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cpu_player_if.sv
// Control/observation bundle of the computer player.
//   enable     : master -> slave, allows new presses to start
//   difficulty : master -> slave, press threshold (larger = presses more often)
//   press      : slave -> master, button-level output
//   busy       : slave -> master, high while a press/gap sequence runs
interface cpu_player_if;
    logic                        enable;
    logic [tow_pkg::LFSR_W-1:0]  difficulty;
    logic                        press;
    logic                        busy;

    modport master (output enable, output difficulty, input press, input busy);
    modport slave  (input enable, input difficulty, output press, output busy);
endinterface

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR with XNOR feedback.
//   clk   : clock, advances on every rising edge
//   reset : asynchronous, active-high; clears q to 0
//   q     : current LFSR value
// XNOR feedback makes all-zero a legal state, so reset to 0 starts the
// sequence 0,1,3,7,... and the all-ones lockup value is never reached.
module lfsr10
    import tow_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else
            q <= {q[LFSR_W-2:0], ~(q[TAP_HI] ^ q[TAP_LO])};
    end

endmodule

// File: rtl/cpu_player.sv
// Computer opponent: turns pseudo-random decisions into press levels that
// are high for HOLD_CYCLES and then forced low for GAP_CYCLES, so the
// downstream edge detector sees one clean 0->1 edge per press.
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : cpu_player_if.slave (enable, difficulty in; press, busy out)
module cpu_player
    import tow_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic         clk,
    input  logic         reset,
    cpu_player_if.slave  bus
);

    localparam int CNT_MAX = max2(HOLD_CYCLES, GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("cpu_player: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("cpu_player: GAP_CYCLES must be >= 1");
    end

    cpu_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [LFSR_W-1:0] lfsr;

    lfsr10 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // IDLE is the decision cycle: the compare uses the pre-shift LFSR value,
    // and because every sequence returns through IDLE the minimum press
    // period is HOLD_CYCLES + GAP_CYCLES + 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.enable && (bus.difficulty > lfsr)) begin
                    state_nxt = PRESS;
                    cnt_nxt   = '0;
                end
            end
            PRESS: begin
                if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Decoded straight from the state register: no input-to-output path,
    // and the async reset drops both outputs immediately.
    assign bus.press = (state == PRESS);
    assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_cpu_player.sv
module tb_cpu_player;
    import tow_pkg::*;

    localparam int H = 2;
    localparam int G = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_player_if bus();

    cpu_player #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Downstream edge detector the player feeds.
    logic press_d = 1'b0;
    always @(posedge clk) press_d <= bus.press;
    wire pulse = bus.press & ~press_d;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: remaining cycles of the current press+gap sequence.
    // Press is high while more than G cycles remain.
    int m_lfsr;
    int m_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_lfsr = 0;
        m_left = 0;
    endfunction

    function automatic void model_step(input logic en, input logic [9:0] d);
        if (m_left == 0) begin
            if (en && (int'(d) > m_lfsr)) m_left = H + G;
        end else begin
            m_left = m_left - 1;
        end
        m_lfsr = ((m_lfsr << 1) & 1023) | ((~((m_lfsr >> 9) ^ (m_lfsr >> 6))) & 1);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step(bus.enable, bus.difficulty);
        #1;
        check("press", 32'(bus.press), 32'(m_left > G));
        check("busy",  32'(bus.busy),  32'(m_left > 0));
        check("lfsr",  32'(dut.u_lfsr.q), 32'(m_lfsr));
    endtask

    // Asserts reset between edges and checks the asynchronous clear.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_press", 32'(bus.press), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_lfsr",  32'(dut.u_lfsr.q), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic [9:0] diff;
        int         cycles;
        int         exp_pulses;
        int         exp_busy;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        int   pulses, busy_cnt, highs;

        vecs[0] = '{1'b1, 10'd1023, 100,  20, 80};
        vecs[1] = '{1'b1, 10'd0,    2100, 0,  0};
        vecs[2] = '{1'b1, 10'd1,    2046, 2,  8};
        vecs[3] = '{1'b0, 10'd1023, 50,   0,  0};
        vecs[4] = '{1'b1, 10'd1023, 7,    2,  6};

        bus.enable     = 1'b0;
        bus.difficulty = '0;
        @(negedge clk);

        foreach (vecs[v]) begin
            do_reset();
            bus.enable     = vecs[v].en;
            bus.difficulty = vecs[v].diff;
            pulses   = 0;
            busy_cnt = 0;
            for (int i = 0; i < vecs[v].cycles; i++) begin
                cycle();
                if (pulse) pulses++;
                if (bus.busy) busy_cnt++;
                if (vecs[v].diff == 10'd0 && ((i + 1) % 1023) == 0)
                    check("lfsr_wrap", 32'(dut.u_lfsr.q), 32'd0);
            end
            check($sformatf("vec%0d_pulses", v), 32'(pulses), 32'(vecs[v].exp_pulses));
            check($sformatf("vec%0d_busy", v), 32'(busy_cnt), 32'(vecs[v].exp_busy));
        end

        // enable dropped one cycle into PRESS: sequence completes, then idle.
        do_reset();
        bus.enable     = 1'b1;
        bus.difficulty = 10'd1023;
        cycle();
        highs = int'(bus.press);
        bus.enable = 1'b0;
        cycle();
        check("hold_after_drop", 32'(bus.press), 32'd1);
        highs += int'(bus.press);
        for (int i = 0; i < 10; i++) begin
            cycle();
            highs += int'(bus.press);
        end
        check("drop_press_cycles", 32'(highs), 32'd2);
        check("drop_idle_press", 32'(bus.press), 32'd0);
        check("drop_idle_busy",  32'(bus.busy),  32'd0);

        // Asynchronous reset in the middle of a press.
        do_reset();
        bus.enable     = 1'b1;
        bus.difficulty = 10'd1023;
        cycle();
        check("pre_reset_press", 32'(bus.press), 32'd1);
        do_reset();
        bus.enable = 1'b0;
        cycle();
        check("restart_lfsr1", 32'(dut.u_lfsr.q), 32'd1);
        cycle();
        check("restart_lfsr3", 32'(dut.u_lfsr.q), 32'd3);
        cycle();
        check("restart_lfsr7", 32'(dut.u_lfsr.q), 32'd7);

        // Randomized enable/difficulty against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 7))
                0:       bus.difficulty = 10'd0;
                1:       bus.difficulty = 10'd1023;
                default: bus.difficulty = 10'($urandom_range(0, 1023));
            endcase
            bus.enable = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_player.md
Name: cpu_player

Overview:
- Computer opponent for Tug of War. Generates button-like press levels that feed the same input path as a human player's key, upstream of the press edge detector.
- A free-running 10-bit LFSR is compared against a difficulty setting from the switches. A small FSM then shapes each "press" into a level that is high for a fixed time and low for a fixed gap.
- The guaranteed low gap means the downstream edge detector always sees a distinct 0->1 edge per press.

Parameters:
- LFSR_W, 10, width of the LFSR and of the difficulty input.
- HOLD_CYCLES, 2, number of cycles the press level stays high per press; must be >= 1.
- GAP_CYCLES, 2, number of cycles the press level is forced low after each press; must be >= 1.

Ports:
- clk  input  1  system clock, all state updates on posedge clk
- reset  input  1  asynchronous, active-high reset
- enable  input  1  allows new presses to start; a press already in progress always completes
- difficulty  input  LFSR_W  unsigned threshold; larger values mean the computer presses more often
- press  output  1  button-level output to the press edge detector
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, active-high): press=0, busy=0, state=IDLE, hold/gap counter=0, lfsr=0. Outputs drop immediately, including in the middle of a press.
- LFSR:
  - Fibonacci, XNOR feedback: lfsr <= {lfsr[8:0], ~(lfsr[9]^lfsr[6])}.
  - Advances every clock edge, regardless of state or enable.
  - Sequence from reset: 0,1,3,7,15,31,...
  - Period 1023; the all-ones value (1023) is the lockup state and is never reached from reset.
- FSM states:
  - IDLE -> PRESS when enable=1 and difficulty > lfsr (unsigned compare against the current, pre-shift lfsr value). Counter is cleared on entry.
  - PRESS: lasts exactly HOLD_CYCLES cycles, then -> RELEASE with counter cleared.
  - RELEASE: lasts exactly GAP_CYCLES cycles, then -> IDLE.
  - IDLE: lasts at least 1 cycle, because it is the decision cycle.
- Outputs are registered-state decoded, with no combinational path from inputs:
  - press = (state==PRESS)
  - busy = (state!=IDLE)
- Latency: press rises in the cycle after the edge at which the IDLE condition was true.
- Minimum press period is HOLD_CYCLES+GAP_CYCLES+1; with defaults that is 5 cycles: high 2, low 3.
- Boundary cases:
  - difficulty=0: never presses.
  - difficulty=1023: presses on every IDLE decision cycle, because lfsr <= 1022.
  - enable falling during PRESS or RELEASE: the sequence completes, then the FSM stays in IDLE.
  - enable and difficulty are sampled only in IDLE.
  - Counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).
- Parameter legality: elaboration fails (assertion) if HOLD_CYCLES<1 or GAP_CYCLES<1.

Decomposition:
- Package tow_pkg holds:
  - typedef enum logic [1:0] {IDLE, PRESS, RELEASE} cpu_state_t
  - localparams LFSR_W=10, TAP_HI=9, TAP_LO=6
- Sub-module lfsr10 (ports: clk, reset, q[9:0]) is instantiated once.
- FSM, counter and comparator live in cpu_player.

Test Plan:
- Reset, then enable=1, difficulty=1023 -> first edge after reset release leads to press=1 for 2 cycles, then 0 for 3, repeating; busy=1 during the 4 non-IDLE cycles.
- enable=1, difficulty=0 for 2100 cycles -> press stays 0 and busy stays 0 throughout; lfsr returns to 0 at cycle 1023 and at 2046.
- enable=1, difficulty=1 -> press at the first edge after reset (lfsr=0), no further press until lfsr=0 again (cycle 1023), then one press; exactly 2 presses in 2046 cycles.
- difficulty=1023, enable dropped one cycle into PRESS -> press still high for 2 cycles total, low gap completes, then press stays 0 while enable=0.
- reset asserted asynchronously mid-PRESS (between edges) -> press=0 and busy=0 immediately; after release, lfsr restarts at 0,1,3,7.
- Chain cpu_player to the press edge detector, difficulty=1023 -> detector emits exactly one 1-cycle pulse per press; 20 pulses over 100 cycles.
